// File: rtl/tx_word_feeder.sv
// Word-to-byte feeder for the debugger UART transmitter: buffers words in a FIFO,
// then hands them to the transmitter one byte at a time with a start/done handshake.
module tx_word_feeder #(
  parameter int unsigned LEN_DATA   = 8,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [LEN_DATA*WORD_BYTES-1:0]        in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  tx_start,
  output logic [LEN_DATA-1:0]                   tx_data,
  input  logic                                  tx_done,
  output logic                                  word_done,
  output logic                                  busy,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  drop_err
);

  localparam int unsigned W   = LEN_DATA * WORD_BYTES;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [W-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [W-1:0]         sh, sh_nxt, sh_shift;
  logic [BCW-1:0]       byte_cnt, byte_cnt_nxt;
  logic [LEN_DATA-1:0]  tx_data_nxt;
  logic                 word_done_nxt;
  logic                 push, pop, full, empty;

  // Byte presented to the transmitter from a given shift-register value.
  function automatic logic [LEN_DATA-1:0] send_byte(input logic [W-1:0] v);
    if (MSB_FIRST) return v[W-1 -: LEN_DATA];
    else           return v[LEN_DATA-1:0];
  endfunction

  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign empty    = (fifo_count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !empty;
  assign sh_shift = MSB_FIRST ? (sh << LEN_DATA) : (sh >> LEN_DATA);

  // Word storage; contents need no reset since occupancy is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      byte_cnt  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      byte_cnt  <= byte_cnt_nxt;
      tx_start  <= (state_nxt == START);
      tx_data   <= tx_data_nxt;
      word_done <= word_done_nxt;
    end
  end

  // Next-state logic; tx_data is loaded on entry to START and held otherwise.
  always_comb begin
    state_nxt     = state;
    sh_nxt        = sh;
    byte_cnt_nxt  = byte_cnt;
    tx_data_nxt   = tx_data;
    word_done_nxt = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          sh_nxt       = mem[rd_ptr];
          byte_cnt_nxt = '0;
          tx_data_nxt  = send_byte(mem[rd_ptr]);
          state_nxt    = START;
        end
      end
      START: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          if (byte_cnt == BCW'(WORD_BYTES - 1)) begin
            word_done_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            sh_nxt       = sh_shift;
            byte_cnt_nxt = byte_cnt + BCW'(1);
            tx_data_nxt  = send_byte(sh_shift);
            state_nxt    = START;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/tx_word_feeder.md
Name: tx_word_feeder

Overview:
- Upstream stage of the UART transmitter in the debugger unit. It accepts full-width words from the debug controller through a valid/ready interface and buffers them in a small FIFO.
- It splits each word into LEN_DATA-bit bytes and drives the transmitter one byte at a time. Each byte goes out with a one-cycle tx_start pulse, and the feeder then waits for the transmitter's tx_done pulse before sending the next byte.

Parameters:
- LEN_DATA, 8: byte width; must match the transmitter's LEN_DATA.
- WORD_BYTES, 4: bytes per word; word width W = LEN_DATA*WORD_BYTES.
- FIFO_DEPTH, 4: word FIFO entries; power of two, at least 2.
- MSB_FIRST, 0: 0 sends byte 0 (bits [LEN_DATA-1:0]) first; 1 sends the most significant byte first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  W  word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word; equals not-full.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  LEN_DATA  byte to the transmitter's input_data; registered.
- tx_done  in  1  one-cycle end-of-byte pulse from the transmitter.
- word_done  out  1  one-cycle pulse after the last byte of a word completes.
- busy  out  1  high while a word is being serialised or the FIFO is non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  words currently stored.
- drop_err  out  1  sticky flag: in_valid seen while in_ready was low.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, fifo_count=0, in_ready=1.
  - tx_start=0, tx_data=0, word_done=0, busy=0, drop_err=0, state IDLE.
  - Reset mid-byte abandons the word silently. The transmitter has its own reset and is not controlled from here.
- FIFO:
  - Push when in_valid && in_ready. Circular write/read pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - No write-through bypass: when full, in_ready=0 even if a pop occurs in that cycle.
  - in_valid && !in_ready sets drop_err; the word is discarded and the FIFO is unchanged. drop_err clears only on reset.
- FSM states IDLE, START, WAIT_DONE:
  - IDLE: if FIFO non-empty, pop the head into shift register sh, set byte_cnt=0, go to START. Otherwise stay.
  - START: tx_start=1 for exactly this cycle. tx_data = sh[LEN_DATA-1:0], or the top byte if MSB_FIRST. Go to WAIT_DONE.
  - WAIT_DONE: tx_start=0 and tx_data held stable. On tx_done:
    - if byte_cnt==WORD_BYTES-1: pulse word_done on the next cycle and go to IDLE.
    - otherwise: shift sh by LEN_DATA toward the send end, byte_cnt+1, go to START.
  - tx_done in IDLE or START is ignored.
- Outputs are Moore/registered. tx_start is never high in the same cycle as tx_done, so the next tx_start arrives at least 1 cycle after tx_done, when the transmitter is back in idle.
- Latency:
  - Push into an empty FIFO at edge N: pop at edge N+1, tx_start high during cycle N+2.
  - tx_done sampled at edge M: next tx_start high during cycle M+1 (same word) or M+2 (next word, via IDLE).
- busy = (state != IDLE) || fifo_count != 0.
- byte_cnt width is clog2(WORD_BYTES), minimum 1 bit.

Test Plan:
- Reset, then push in_data=0xDDCCBBAA once (MSB_FIRST=0), answering each tx_start with tx_done 20 cycles later. Expect tx_data sequence AA, BB, CC, DD; 4 tx_start pulses; one word_done after the 4th tx_done; busy then drops to 0.
- Push 0x11223344 with MSB_FIRST=1. Expect tx_data 11, 22, 33, 44.
- Back-pressure: push 5 words with FIFO_DEPTH=4 and no tx_done. The first word is popped into sh, so 4 more fit and fifo_count=4, in_ready=0. A 6th push sets drop_err=1, and fifo_count stays 4.
- Simultaneous push/pop: with fifo_count=2, push on the same edge the FSM pops. Expect fifo_count to remain 2 and order preserved: words come out exactly in push order.
- Spurious tx_done pulse while in IDLE with an empty FIFO. Expect no tx_start and no word_done.
- Assert rst for 1 cycle mid-word after the 2nd byte's tx_start. Expect all outputs at reset values immediately (async), FIFO empty, and no further tx_start until a new push.
